// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI master: FSM state encodings and frame layout.
package spi_master_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam int         FRAME_BITS = 16;
  localparam logic [3:0] FRAME_LAST = 4'd15;
  localparam logic [3:0] DATA_START = 4'd8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_half_timer.sv
// Free-running half-period counter: wraps 0..HALF-1 while run is high, ticks on HALF-1.
module spi_half_timer #(
  parameter int HALF = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!run || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = run && (cnt_reg == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI master issuing one {addr, rw, data} frame per accepted request and
// returning the read byte (or 0 for writes) on a single-cycle response strobe.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int HALF   = 50,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sclk_pin,
  output logic              cs_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
);

  logic [2:0]            state_reg;
  logic                  phase_reg;   // 0 = sclk low phase, 1 = sclk high phase
  logic [3:0]            bit_reg;
  logic [FRAME_BITS-1:0] tx_reg;
  logic [DATA_W-1:0]     rx_reg;
  logic                  rw_reg;
  logic                  miso_meta_reg;
  logic                  miso_sync_reg;
  logic                  cs_reg;
  logic                  sclk_reg;
  logic                  mosi_reg;
  logic                  ready_reg;
  logic                  rsp_valid_reg;
  logic [DATA_W-1:0]     rsp_rdata_reg;
  logic                  tick;

  spi_half_timer #(.HALF(HALF)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_reg != ST_IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta_reg <= 1'b0;
      miso_sync_reg <= 1'b0;
    end else begin
      miso_meta_reg <= miso_pin;
      miso_sync_reg <= miso_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= 1'b0;
      bit_reg       <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      rw_reg        <= RW_WRITE;
      cs_reg        <= 1'b1;
      sclk_reg      <= 1'b1;
      mosi_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ready_reg <= 1'b1;
          if (req_valid && ready_reg) begin
            state_reg <= ST_SETUP;
            ready_reg <= 1'b0;
            cs_reg    <= 1'b0;
            rw_reg    <= req_rw;
            bit_reg   <= '0;
            phase_reg <= 1'b0;
            rx_reg    <= '0;
            // Read frames clock zeros out during the data half.
            tx_reg    <= {req_addr, req_rw, (req_rw == RW_READ) ? '0 : req_wdata};
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state_reg <= ST_SHIFT;
            sclk_reg  <= 1'b0;
            mosi_reg  <= tx_reg[FRAME_BITS-1];
            tx_reg    <= {tx_reg[FRAME_BITS-2:0], 1'b0};
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!phase_reg) begin
              // End of low phase: the slave has had the whole phase to drive miso.
              sclk_reg  <= 1'b1;
              phase_reg <= 1'b1;
              if (bit_reg >= DATA_START) begin
                rx_reg <= {rx_reg[DATA_W-2:0], miso_sync_reg};
              end
            end else if (bit_reg == FRAME_LAST) begin
              state_reg <= ST_HOLD;
            end else begin
              bit_reg   <= bit_reg + 4'd1;
              phase_reg <= 1'b0;
              sclk_reg  <= 1'b0;
              mosi_reg  <= tx_reg[FRAME_BITS-1];
              tx_reg    <= {tx_reg[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state_reg     <= ST_GAP;
            cs_reg        <= 1'b1;
            mosi_reg      <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= (rw_reg == RW_READ) ? rx_reg : '0;
          end
        end
        ST_GAP: begin
          if (tick) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign sclk_pin  = sclk_reg;
  assign cs_pin    = cs_reg;
  assign mosi_pin  = mosi_reg;

endmodule
